// File: rtl/pkt_split_pkg.sv
// Shared types and sizing helpers for the header/payload splitter.
package pkt_split_pkg;

  typedef enum logic [1:0] {HDR, PLD, DROP} state_t;

  localparam int TRUNC_CNT_W = 16;
  localparam int DEF_SEQ_W   = 8;

  // Layout of the metadata word at its default width; the top packs the same fields generically.
  typedef struct packed {
    logic                 has_payload;
    logic [DEF_SEQ_W-1:0] seq;
  } meta_t;

  function automatic int beat_cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/axis_out_slice.sv
// One-entry AXI-Stream output register slice with an optional sideband user field.
module axis_out_slice #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic [USER_W-1:0] in_user,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic [USER_W-1:0] out_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              slot_free
);

  // The parent only asserts load when slot_free is high, so a held beat is never overwritten.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_user  <= in_user;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_hdr_split.sv
// Splits each packet into a single-beat header (with {has_payload, seq} metadata)
// and a payload stream, truncating payloads longer than MAX_PLD_BEATS.
module pkt_hdr_split
  import pkt_split_pkg::*;
#(
  parameter int TDATA_NUM_BYTES      = 64,
  parameter int USER_META_DATA_WIDTH = 9,
  parameter int MAX_PLD_BEATS        = 143
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TDATA_NUM_BYTES*8-1:0]      s_axis_if_tx_tdata,
  input  logic [TDATA_NUM_BYTES-1:0]        s_axis_if_tx_tkeep,
  input  logic                              s_axis_if_tx_tvalid,
  input  logic                              s_axis_if_tx_tlast,
  output logic                              s_axis_if_tx_tready,
  output logic [TDATA_NUM_BYTES*8-1:0]      m_axis_hdr_tdata,
  output logic [TDATA_NUM_BYTES-1:0]        m_axis_hdr_tkeep,
  output logic                              m_axis_hdr_tvalid,
  output logic                              m_axis_hdr_tlast,
  input  logic                              m_axis_hdr_tready,
  output logic [USER_META_DATA_WIDTH-1:0]   user_metadata_out,
  output logic                              user_metadata_out_valid,
  output logic [TDATA_NUM_BYTES*8-1:0]      m_axis_pld_tdata,
  output logic [TDATA_NUM_BYTES-1:0]        m_axis_pld_tkeep,
  output logic                              m_axis_pld_tvalid,
  output logic                              m_axis_pld_tlast,
  input  logic                              m_axis_pld_tready,
  output logic [TRUNC_CNT_W-1:0]            trunc_cnt
);

  localparam int DATA_W     = TDATA_NUM_BYTES * 8;
  localparam int SEQ_W      = USER_META_DATA_WIDTH - 1;
  localparam int BEAT_CNT_W = beat_cnt_w(MAX_PLD_BEATS);

  state_t                  state;
  logic [SEQ_W-1:0]        seq;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic [BEAT_CNT_W-1:0]   beat_cnt_inc;
  logic                    at_max;
  logic                    hdr_free;
  logic                    pld_free;
  logic                    accept;
  logic                    hdr_load;
  logic                    pld_load;
  logic                    pld_last_in;
  logic                    pld_user_unused;

  always_comb begin
    s_axis_if_tx_tready = 1'b1;
    case (state)
      HDR:     s_axis_if_tx_tready = hdr_free;
      PLD:     s_axis_if_tx_tready = pld_free;
      default: s_axis_if_tx_tready = 1'b1;
    endcase
  end

  assign accept       = s_axis_if_tx_tvalid && s_axis_if_tx_tready;
  assign hdr_load     = accept && (state == HDR);
  assign pld_load     = accept && (state == PLD);
  assign beat_cnt_inc = beat_cnt + BEAT_CNT_W'(1);
  // A beat that carries tlast at the limit ends the packet normally; only a non-last beat truncates.
  assign at_max       = (beat_cnt_inc == BEAT_CNT_W'(MAX_PLD_BEATS));
  assign pld_last_in  = s_axis_if_tx_tlast || at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HDR;
      seq       <= '0;
      beat_cnt  <= '0;
      trunc_cnt <= '0;
    end else if (accept) begin
      case (state)
        HDR: begin
          seq <= seq + SEQ_W'(1);
          if (!s_axis_if_tx_tlast) begin
            beat_cnt <= '0;
            state    <= PLD;
          end
        end
        PLD: begin
          beat_cnt <= beat_cnt_inc;
          if (s_axis_if_tx_tlast) begin
            state <= HDR;
          end else if (at_max) begin
            state <= DROP;
            if (trunc_cnt != '1) trunc_cnt <= trunc_cnt + TRUNC_CNT_W'(1);
          end
        end
        DROP: begin
          if (s_axis_if_tx_tlast) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

  axis_out_slice #(
    .DATA_W (DATA_W),
    .KEEP_W (TDATA_NUM_BYTES),
    .USER_W (USER_META_DATA_WIDTH)
  ) u_hdr_slice (
    .clk       (clk),
    .rst       (rst),
    .load      (hdr_load),
    .in_data   (s_axis_if_tx_tdata),
    .in_keep   (s_axis_if_tx_tkeep),
    .in_last   (1'b1),
    .in_user   ({~s_axis_if_tx_tlast, seq}),
    .out_data  (m_axis_hdr_tdata),
    .out_keep  (m_axis_hdr_tkeep),
    .out_last  (m_axis_hdr_tlast),
    .out_user  (user_metadata_out),
    .out_valid (m_axis_hdr_tvalid),
    .out_ready (m_axis_hdr_tready),
    .slot_free (hdr_free)
  );

  axis_out_slice #(
    .DATA_W (DATA_W),
    .KEEP_W (TDATA_NUM_BYTES),
    .USER_W (1)
  ) u_pld_slice (
    .clk       (clk),
    .rst       (rst),
    .load      (pld_load),
    .in_data   (s_axis_if_tx_tdata),
    .in_keep   (s_axis_if_tx_tkeep),
    .in_last   (pld_last_in),
    .in_user   (1'b0),
    .out_data  (m_axis_pld_tdata),
    .out_keep  (m_axis_pld_tkeep),
    .out_last  (m_axis_pld_tlast),
    .out_user  (pld_user_unused),
    .out_valid (m_axis_pld_tvalid),
    .out_ready (m_axis_pld_tready),
    .slot_free (pld_free)
  );

  assign user_metadata_out_valid = m_axis_hdr_tvalid;

endmodule

// File: tb/tb_pkt_hdr_split.sv
// Directed bench for pkt_hdr_split: stimulus pushes expected beats into queues,
// negedge monitors pop and compare whenever an output handshake is about to complete.
module tb_pkt_hdr_split;

  localparam int NB  = 64;
  localparam int DW  = NB * 8;
  localparam int MW  = 9;
  localparam int MAX = 4;
  localparam logic [NB-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [NB-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] hdr_tdata;
  logic [NB-1:0] hdr_tkeep;
  logic          hdr_tvalid;
  logic          hdr_tlast;
  logic          hdr_tready = 1'b1;
  logic [MW-1:0] meta;
  logic          meta_valid;
  logic [DW-1:0] pld_tdata;
  logic [NB-1:0] pld_tkeep;
  logic          pld_tvalid;
  logic          pld_tlast;
  logic          pld_tready = 1'b1;
  logic [15:0]   trunc_cnt;

  pkt_hdr_split #(
    .TDATA_NUM_BYTES      (NB),
    .USER_META_DATA_WIDTH (MW),
    .MAX_PLD_BEATS        (MAX)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .s_axis_if_tx_tdata      (s_tdata),
    .s_axis_if_tx_tkeep      (s_tkeep),
    .s_axis_if_tx_tvalid     (s_tvalid),
    .s_axis_if_tx_tlast      (s_tlast),
    .s_axis_if_tx_tready     (s_tready),
    .m_axis_hdr_tdata        (hdr_tdata),
    .m_axis_hdr_tkeep        (hdr_tkeep),
    .m_axis_hdr_tvalid       (hdr_tvalid),
    .m_axis_hdr_tlast        (hdr_tlast),
    .m_axis_hdr_tready       (hdr_tready),
    .user_metadata_out       (meta),
    .user_metadata_out_valid (meta_valid),
    .m_axis_pld_tdata        (pld_tdata),
    .m_axis_pld_tkeep        (pld_tkeep),
    .m_axis_pld_tvalid       (pld_tvalid),
    .m_axis_pld_tlast        (pld_tlast),
    .m_axis_pld_tready       (pld_tready),
    .trunc_cnt               (trunc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic [MW-1:0] meta;
  } hdr_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } pld_exp_t;

  hdr_exp_t hdr_q[$];
  pld_exp_t pld_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] pat(input logic [31:0] id);
    return {16{id}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: a beat is transferred at the next posedge when valid && ready at the negedge.
  always @(negedge clk) begin
    if (!rst && hdr_tvalid && hdr_tready) begin
      if (hdr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL hdr_unexpected: got data %0h meta %0h expected nothing", hdr_tdata, meta);
      end else begin
        hdr_exp_t e;
        e = hdr_q.pop_front();
        $display("hdr beat: data=%0h keep=%0h meta=%0h", hdr_tdata[31:0], hdr_tkeep, meta);
        chk("hdr_data", hdr_tdata, e.data);
        chk("hdr_keep", DW'(hdr_tkeep), DW'(e.keep));
        chk("hdr_last", DW'(hdr_tlast), DW'(1'b1));
        chk("hdr_meta", DW'(meta), DW'(e.meta));
        chk("meta_valid", DW'(meta_valid), DW'(1'b1));
      end
    end
    if (!rst && pld_tvalid && pld_tready) begin
      if (pld_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pld_unexpected: got data %0h expected nothing", pld_tdata);
      end else begin
        pld_exp_t p;
        p = pld_q.pop_front();
        $display("pld beat: data=%0h keep=%0h last=%0b", pld_tdata[31:0], pld_tkeep, pld_tlast);
        chk("pld_data", pld_tdata, p.data);
        chk("pld_keep", DW'(pld_tkeep), DW'(p.keep));
        chk("pld_last", DW'(pld_tlast), DW'(p.last));
      end
    end
  end

  // Called at posedge+1; leaves the bench at posedge+1 after the beat is accepted.
  task automatic send(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) begin
      total++; bad++;
      $display("FAIL send_timeout: tready=%0b expected 1", s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic hdr_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l,
                          input logic [MW-1:0] m);
    hdr_q.push_back('{d, k, m});
    send(d, k, l);
  endtask

  task automatic pld_beat(input logic [DW-1:0] d, input logic [NB-1:0] k,
                          input logic l_in, input logic l_exp);
    pld_q.push_back('{d, k, l_exp});
    send(d, k, l_in);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((hdr_q.size() != 0 || pld_q.size() != 0) && n < 500) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    total++;
    if (hdr_q.size() != 0 || pld_q.size() != 0) begin
      bad++;
      $display("FAIL %s: pending hdr=%0d pld=%0d expected 0", name, hdr_q.size(), pld_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_valid", DW'(hdr_tvalid), DW'(1'b0));
    chk("rst_pld_valid", DW'(pld_tvalid), DW'(1'b0));
    chk("rst_meta_valid", DW'(meta_valid), DW'(1'b0));
    chk("rst_hdr_last", DW'(hdr_tlast), DW'(1'b0));
    chk("rst_meta", DW'(meta), DW'(0));
    chk("rst_trunc", DW'(trunc_cnt), DW'(0));
    chk("rst_tready", DW'(s_tready), DW'(1'b1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat packet: header only, has_payload=0, seq 0.
    hdr_beat(pat(32'hA0000001), ONES, 1'b1, 9'h000);
    drain("drain_single");

    // 3-beat packet: seq 1 with payload, last payload beat partial.
    hdr_beat(pat(32'hB0000000), ONES, 1'b0, 9'h101);
    pld_beat(pat(32'hB0000001), ONES, 1'b0, 1'b0);
    pld_beat(pat(32'hB0000002), 64'h0F, 1'b1, 1'b1);
    drain("drain_3beat");

    // Header back-pressure: second header must wait, first must hold stable.
    hdr_tready = 1'b0;
    hdr_beat(pat(32'hC0000001), ONES, 1'b1, 9'h002);
    fork
      hdr_beat(pat(32'hC0000002), ONES, 1'b1, 9'h003);
      begin
        repeat (3) @(negedge clk);
        chk("stall_tready", DW'(s_tready), DW'(1'b0));
        chk("stall_hdr_valid", DW'(hdr_tvalid), DW'(1'b1));
        chk("stall_hdr_hold", hdr_tdata, pat(32'hC0000001));
        chk("stall_meta_hold", DW'(meta), DW'(9'h002));
        @(posedge clk);
        #1;
        hdr_tready = 1'b1;
      end
    join
    drain("drain_stall");

    // 8-beat packet: 7 payload beats offered, 4 forwarded (last forced), 3 dropped.
    hdr_beat(pat(32'hD0000000), ONES, 1'b0, 9'h104);
    pld_beat(pat(32'hD0000001), ONES, 1'b0, 1'b0);
    pld_beat(pat(32'hD0000002), 64'h0, 1'b0, 1'b0);
    pld_beat(pat(32'hD0000003), ONES, 1'b0, 1'b0);
    pld_beat(pat(32'hD0000004), ONES, 1'b0, 1'b1);
    send(pat(32'hD0000005), ONES, 1'b0);
    send(pat(32'hD0000006), ONES, 1'b0);
    send(pat(32'hD0000007), ONES, 1'b1);
    drain("drain_trunc");
    chk("trunc_cnt_1", DW'(trunc_cnt), DW'(16'd1));

    // Exactly MAX payload beats ending with tlast: not truncated.
    hdr_beat(pat(32'hE0000000), ONES, 1'b0, 9'h105);
    pld_beat(pat(32'hE0000001), ONES, 1'b0, 1'b0);
    pld_beat(pat(32'hE0000002), ONES, 1'b0, 1'b0);
    pld_beat(pat(32'hE0000003), ONES, 1'b0, 1'b0);
    pld_beat(pat(32'hE0000004), 64'hFF, 1'b1, 1'b1);
    drain("drain_exact");
    chk("trunc_cnt_exact", DW'(trunc_cnt), DW'(16'd1));

    // Normal 2-beat packet after truncation.
    hdr_beat(pat(32'hF0000000), ONES, 1'b0, 9'h106);
    pld_beat(pat(32'hF0000001), 64'h3, 1'b1, 1'b1);
    drain("drain_after_trunc");

    // Reset mid-payload while the payload slot is held.
    pld_tready = 1'b0;
    hdr_beat(pat(32'h11000000), ONES, 1'b0, 9'h107);
    pld_beat(pat(32'h11000001), ONES, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_pld_valid", DW'(pld_tvalid), DW'(1'b1));
    chk("pre_rst_hdr_drained", DW'(hdr_q.size()), DW'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_hdr_valid", DW'(hdr_tvalid), DW'(1'b0));
    chk("mid_rst_pld_valid", DW'(pld_tvalid), DW'(1'b0));
    chk("mid_rst_meta_valid", DW'(meta_valid), DW'(1'b0));
    chk("mid_rst_trunc", DW'(trunc_cnt), DW'(0));
    chk("mid_rst_pld_data", pld_tdata, '0);
    pld_q.delete();
    hdr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pld_tready = 1'b1;
    @(posedge clk);
    #1;
    hdr_beat(pat(32'h22000000), ONES, 1'b1, 9'h000);
    drain("drain_post_rst");

    // Back-to-back single-beat packets: seq 1..255, then wrap to 0.
    for (int i = 1; i < 256; i++) begin
      hdr_beat(pat(32'h33000000 + 32'(i)), ONES, 1'b1, MW'(i));
    end
    hdr_beat(pat(32'h44000000), ONES, 1'b1, 9'h000);
    drain("drain_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_hdr_split.md
Name: pkt_hdr_split

Overview:
- Ingress stage directly upstream of the P4 packet-processing IP.
- Splits each incoming AXI-Stream packet into two outputs:
  - the first 64-byte beat, sent to the P4 IP as a single-beat packet with its user metadata;
  - the remaining payload beats, sent on a separate stream to the payload buffer.
- Tags each packet with a has_payload flag and a wrapping sequence number so the downstream merger can re-pair header and payload.
- Truncates over-length packets and counts the truncations.

Parameters:
- TDATA_NUM_BYTES, 64: bytes per beat; tdata width is TDATA_NUM_BYTES*8.
- USER_META_DATA_WIDTH, 9: metadata width to the P4 IP; bit MSB = has_payload, lower bits = sequence number.
- MAX_PLD_BEATS, 143: maximum payload beats forwarded per packet (header beat excluded); must be >= 1.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_if_tx_tdata  in  TDATA_NUM_BYTES*8  input packet data.
- s_axis_if_tx_tkeep  in  TDATA_NUM_BYTES  input byte enables.
- s_axis_if_tx_tvalid  in  1  input valid.
- s_axis_if_tx_tlast  in  1  input end of packet.
- s_axis_if_tx_tready  out  1  input ready.
- m_axis_hdr_tdata  out  TDATA_NUM_BYTES*8  header beat to the P4 IP.
- m_axis_hdr_tkeep  out  TDATA_NUM_BYTES  header byte enables.
- m_axis_hdr_tvalid  out  1  header valid.
- m_axis_hdr_tlast  out  1  always 1 when m_axis_hdr_tvalid=1.
- m_axis_hdr_tready  in  1  header ready.
- user_metadata_out  out  USER_META_DATA_WIDTH  {has_payload, seq}.
- user_metadata_out_valid  out  1  equals m_axis_hdr_tvalid.
- m_axis_pld_tdata  out  TDATA_NUM_BYTES*8  payload data.
- m_axis_pld_tkeep  out  TDATA_NUM_BYTES  payload byte enables.
- m_axis_pld_tvalid  out  1  payload valid.
- m_axis_pld_tlast  out  1  payload end of packet.
- m_axis_pld_tready  in  1  payload ready.
- trunc_cnt  out  16  count of truncated packets; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, rst=1):
  - all tvalid and user_metadata_out_valid = 0; all data, tkeep, tlast and metadata registers = 0;
  - state = HDR; seq = 0; beat_cnt = 0; trunc_cnt = 0.
- Reset mid-packet discards the partial packet. The first beat accepted after reset is treated as a header.
- Each output has a one-entry register slice:
  - slot_free = !tvalid || tready;
  - 1-cycle latency from input acceptance to output valid;
  - full throughput of one beat per cycle when downstream ready stays high.
- s_axis_if_tx_tready:
  - HDR: header slot_free.
  - PLD: payload slot_free.
  - DROP: 1.
- Input beats are accepted only when tvalid && tready. Output data, tkeep and tlast are held stable while tvalid=1 && tready=0.
- FSM:
  - HDR, on accepted beat:
    - load the header slot with tdata/tkeep and tlast=1;
    - metadata = {~s_tlast, seq}; seq increments, wrapping 2^(W-1)-1 -> 0;
    - if s_tlast=1, stay in HDR; else beat_cnt=0 and go to PLD.
  - PLD, on accepted beat:
    - load the payload slot; beat_cnt++;
    - if s_tlast=1: pld_tlast=1, go to HDR;
    - else if beat_cnt reaches MAX_PLD_BEATS: force pld_tlast=1, increment trunc_cnt (saturating), go to DROP;
    - else pld_tlast=0.
  - DROP: accept and discard beats; on s_tlast=1 go to HDR.
- Truncation boundary: a packet of exactly MAX_PLD_BEATS payload beats, whose last beat has s_tlast=1, is NOT truncated.
- tkeep is passed through unmodified, including all-zero tkeep. No realignment is done.
- Header and payload outputs stall independently. Header N+1 may be emitted before payload N drains only if payload N's tlast has already been accepted into its slot.

Decomposition:
- Package pkt_split_pkg:
  - state enum {HDR, PLD, DROP};
  - metadata struct {has_payload, seq};
  - constants for the beat counter width ($clog2(MAX_PLD_BEATS+1)) and trunc_cnt width (16).
- Sub-module axis_out_slice: one-entry register slice (data, keep, last, plus optional user field), instantiated twice.

Test Plan:
- Single-beat packet, tdata=A, tkeep all-ones, tlast=1 -> header tdata=A, tlast=1; metadata=9'h000; no payload beat; state returns to HDR.
- 3-beat packet after the previous one (tkeep of last beat = 0x0F) -> metadata=9'h101; payload 2 beats, last with tkeep=0x0F, tlast=1; seq increments to 2.
- m_axis_hdr_tready=0 while a second packet arrives -> header slot holds stable, s_axis_if_tx_tready=0; release ready -> both headers delivered in order, no loss or duplication.
- MAX_PLD_BEATS=4, 8-beat packet -> 4 payload beats with tlast forced on the 4th; 3 beats dropped; trunc_cnt=1; the following 2-beat packet is handled normally.
- 256 consecutive single-beat packets -> seq 0..255, then the next packet has metadata seq=0.
- rst asserted mid-payload with pld_tvalid=1 -> all valids drop immediately; after release the next accepted beat appears on the header output with seq=0.
